cpu_core: RTL and testbench

Single-cycle 8-bit processor core (module `cpu_core`) that fetches one 32-bit instruction per clock from an external instruction memory, executes it on an 8×8-bit register file, and updates a 32-bit program counter. It sits between the top-level clock/reset and a byte-addressed instruction ROM, which returns the little-endian word at `PC` combinationally.

---
 rtl/cpu_core_if.sv | 22 ++
 rtl/cpu_core.sv | 159 +++++++++++++++
 tb/tb_cpu_core.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_if.sv
// Instruction-fetch bus between cpu_core and a byte-addressed instruction ROM.
// The core presents the registered fetch address on PC.
// The ROM returns the little-endian word at that address on INSTRUCTION,
// combinationally, within the same cycle.
interface cpu_core_if;

   logic [31:0] PC;
   logic [31:0] INSTRUCTION;

   // Core side: drives the fetch address and consumes the instruction word.
   modport master (
      output PC,
      input  INSTRUCTION
   );

   // Memory side: observes the fetch address and returns the word.
   modport slave (
      input  PC,
      output INSTRUCTION
   );

endinterface

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 8-bit processor with an 8 x 8-bit register file
// and a 32-bit byte-addressed program counter.
//
// Each rising edge of CLK retires exactly one instruction. Decode, register
// read, ALU and next-PC selection are all combinational; the PC and the
// register write update together at the edge.
//
// Optional feature macro: CPU_BRANCH_EN
//   defined   -> opcodes 0x06 (j) and 0x07 (beq) perform PC-relative jumps
//   undefined -> those opcodes behave as NOPs and no branch hardware exists
module cpu_core (
   input  logic       CLK,
   input  logic       RESET,
   cpu_core_if.master imem
);

   // Opcode encodings. Any value not listed here executes as a NOP.
   typedef enum logic [7:0] {
      OP_LOADI = 8'h00,
      OP_MOV   = 8'h01,
      OP_AND   = 8'h02,
      OP_OR    = 8'h03,
      OP_ADD   = 8'h04,
      OP_SUB   = 8'h05,
      OP_J     = 8'h06,
      OP_BEQ   = 8'h07
   } opcode_e;

   // Architectural state
   logic [31:0] pc_q;
   logic [7:0]  regs [8];

   // Instruction fields
   logic [31:0] instr;
   opcode_e     op;
   logic [7:0]  rd_field;
   logic [7:0]  rs1_field;
   logic [7:0]  imm;
   logic [2:0]  rd_idx;
   logic [2:0]  rs1_idx;
   logic [2:0]  rs2_idx;

   // Register read data
   logic [7:0]  rs1_val;
   logic [7:0]  rs2_val;

   // Execute results
   logic        wr_en;
   logic [7:0]  wr_data;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;

`ifdef CPU_BRANCH_EN
   logic [31:0] branch_target;
   logic [7:0]  cmp_diff;
`endif

   // Only the low three bits of the register fields select a register.
   // The upper bits carry no meaning except as the branch offset, so they
   // are folded into a deliberately unused signal.
   logic        unused_bits;

   assign instr     = imem.INSTRUCTION;
   assign op        = opcode_e'(instr[31:24]);
   assign rd_field  = instr[23:16];
   assign rs1_field = instr[15:8];
   assign imm       = instr[7:0];

   assign rd_idx    = rd_field[2:0];
   assign rs1_idx   = rs1_field[2:0];
   assign rs2_idx   = imm[2:0];

   assign unused_bits = ^{rd_field[7:3], rs1_field[7:3]};

   // Two combinational read ports. A register written at the previous edge
   // is already visible here.
   assign rs1_val = regs[rs1_idx];
   assign rs2_val = regs[rs2_idx];

   // Sequential fall-through address; wraps naturally at 2^32.
   assign pc_plus4 = pc_q + 32'd4;

`ifdef CPU_BRANCH_EN
   // The offset is a signed word count relative to the following
   // instruction, so it is sign-extended and scaled by four.
   assign branch_target = pc_plus4 + {{22{rd_field[7]}}, rd_field, 2'b00};
   assign cmp_diff      = rs1_val - rs2_val;
`endif

   // Decode and execute: choose the register write and the next PC.
   always_comb begin
      next_pc = pc_plus4;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      case (op)
         OP_LOADI: begin
            wr_en   = 1'b1;
            wr_data = imm;
         end
         OP_MOV: begin
            wr_en   = 1'b1;
            wr_data = rs2_val;
         end
         OP_AND: begin
            wr_en   = 1'b1;
            wr_data = rs1_val & rs2_val;
         end
         OP_OR: begin
            wr_en   = 1'b1;
            wr_data = rs1_val | rs2_val;
         end
         OP_ADD: begin
            wr_en   = 1'b1;
            wr_data = rs1_val + rs2_val;
         end
         OP_SUB: begin
            wr_en   = 1'b1;
            wr_data = rs1_val + (~rs2_val + 8'd1);
         end
`ifdef CPU_BRANCH_EN
         OP_J: begin
            next_pc = branch_target;
         end
         OP_BEQ: begin
            if (cmp_diff == 8'h00) begin
               next_pc = branch_target;
            end
         end
`endif
         default: begin
         end
      endcase
   end

   // Program counter. An asynchronous reset returns the fetch to address 0
   // and discards whatever instruction was in flight.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pc_q <= 32'd0;
      end else begin
         pc_q <= next_pc;
      end
   end

   // Register file write port. Reset clears every register, and a reset that
   // arrives mid-cycle suppresses the pending write.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= 8'h00;
         end
      end else if (wr_en) begin
         regs[rd_idx] <= wr_data;
      end
   end

   assign imem.PC = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed testbench for cpu_core. The bench plays the role of instruction
// memory by driving the instruction bus directly, one word per cycle. It
// checks the PC and the register file against hand-computed values.
module tb_cpu_core;

   localparam logic [31:0] NOP_WORD = 32'h0800_0000;

   logic CLK = 1'b0;
   logic RESET = 1'b0;

   cpu_core_if bus ();

   cpu_core dut (
      .CLK   (CLK),
      .RESET (RESET),
      .imem  (bus)
   );

   int num_checks = 0;
   int num_fails = 0;

   // 100 MHz-style free-running clock
   always #5 CLK = ~CLK;

   // Build an instruction word from its four byte fields
   function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c);
      return {op, a, b, c};
   endfunction

   // Present one instruction and let it retire; sample 1 time unit after the edge
   task automatic step(input logic [31:0] word);
      bus.INSTRUCTION = word;
      @(posedge CLK);
      #1;
   endtask

   // Assert reset, then release it on a falling edge so the next rising edge
   // executes the instruction at address 0
   task automatic do_reset();
      bus.INSTRUCTION = NOP_WORD;
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc;
      do_reset();
      num_checks++;
      if (bus.PC !== 32'd0) begin
         num_fails++;
         $display("[TB] FAIL reset_pc_initial: got %h expected %h", bus.PC, 32'd0);
      end
      step(ins(8'h00, 8'h01, 8'h00, 8'hAA));
      step(ins(8'h00, 8'h02, 8'h00, 8'h55));
      num_checks++;
      if (bus.PC !== 32'd8 || dut.regs[1] !== 8'hAA) begin
         num_fails++;
         $display("[TB] FAIL reset_preload: pc %h r1 %h expected pc 8 r1 aa", bus.PC, dut.regs[1]);
      end
      // Asynchronous assertion mid-cycle, with a write pending on the bus
      #2;
      bus.INSTRUCTION = ins(8'h00, 8'h03, 8'h00, 8'h77);
      RESET = 1'b0;
      #1;
      num_checks++;
      if (bus.PC !== 32'd0) begin
         num_fails++;
         $display("[TB] FAIL reset_async_pc: got %h expected %h", bus.PC, 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
         num_checks++;
         if (dut.regs[i] !== 8'h00) begin
            num_fails++;
            $display("[TB] FAIL reset_async_reg%0d: got %h expected 00", i, dut.regs[i]);
         end
      end
      // Held through a clock edge, the pending write must stay suppressed
      @(posedge CLK);
      #1;
      num_checks++;
      if (bus.PC !== 32'd0 || dut.regs[3] !== 8'h00) begin
         num_fails++;
         $display("[TB] FAIL reset_held: pc %h r3 %h expected pc 0 r3 00", bus.PC, dut.regs[3]);
      end
      bus.INSTRUCTION = NOP_WORD;
      @(negedge CLK);
      RESET = 1'b1;
      exp_pc = 32'd0;
      for (int i = 0; i < 2; i++) begin
         step(NOP_WORD);
         exp_pc = exp_pc + 32'd4;
         num_checks++;
         if (bus.PC !== exp_pc) begin
            num_fails++;
            $display("[TB] FAIL reset_pc_seq%0d: got %h expected %h", i, bus.PC, exp_pc);
         end
      end
   endtask

   task automatic test_alu();
      logic [31:0] words [4];
      logic [2:0]  dsts  [4];
      logic [7:0]  exps  [4];
      words[0] = ins(8'h04, 8'h07, 8'h04, 8'h03); dsts[0] = 3'd7; exps[0] = 8'h32;
      words[1] = ins(8'h02, 8'h07, 8'h04, 8'h03); dsts[1] = 3'd7; exps[1] = 8'h19;
      words[2] = ins(8'h03, 8'h07, 8'h04, 8'h03); dsts[2] = 3'd7; exps[2] = 8'h19;
      words[3] = ins(8'h01, 8'h05, 8'h00, 8'h04); dsts[3] = 3'd5; exps[3] = 8'h19;
      for (int k = 0; k < 4; k++) begin
         do_reset();
         step(ins(8'h00, 8'h04, 8'h00, 8'h19));
         step(ins(8'h00, 8'h03, 8'h00, 8'h19));
         step(words[k]);
         num_checks++;
         if (dut.regs[dsts[k]] !== exps[k]) begin
            num_fails++;
            $display("[TB] FAIL alu_op%0d: r%0d got %h expected %h", k, dsts[k], dut.regs[dsts[k]], exps[k]);
         end
      end
   endtask

   task automatic test_sub_wrap();
      do_reset();
      step(ins(8'h00, 8'h01, 8'h00, 8'h00));
      step(ins(8'h00, 8'h02, 8'h00, 8'h01));
      step(ins(8'h05, 8'h06, 8'h01, 8'h02));
      num_checks++;
      if (dut.regs[6] !== 8'hFF) begin
         num_fails++;
         $display("[TB] FAIL sub_wrap: r6 got %h expected ff", dut.regs[6]);
      end
      step(ins(8'h00, 8'h05, 8'h00, 8'h02));
      step(ins(8'h04, 8'h07, 8'h06, 8'h05));
      num_checks++;
      if (dut.regs[7] !== 8'h01 || bus.PC !== 32'd20) begin
         num_fails++;
         $display("[TB] FAIL add_wrap: r7 %h pc %h expected r7 01 pc 14", dut.regs[7], bus.PC);
      end
   endtask

   task automatic test_beq();
      logic [31:0] exp_taken;
      logic [31:0] exp_not;
`ifdef CPU_BRANCH_EN
      exp_taken = 32'd20;
`else
      exp_taken = 32'd12;
`endif
      exp_not = 32'd12;
      do_reset();
      step(ins(8'h00, 8'h04, 8'h00, 8'h19));
      step(ins(8'h00, 8'h03, 8'h00, 8'h19));
      step(32'h0702_0304);
      num_checks++;
      if (bus.PC !== exp_taken) begin
         num_fails++;
         $display("[TB] FAIL beq_taken: pc got %h expected %h", bus.PC, exp_taken);
      end
      do_reset();
      step(ins(8'h00, 8'h04, 8'h00, 8'h19));
      step(ins(8'h00, 8'h03, 8'h00, 8'h01));
      step(32'h0702_0304);
      num_checks++;
      if (bus.PC !== exp_not) begin
         num_fails++;
         $display("[TB] FAIL beq_not_taken: pc got %h expected %h", bus.PC, exp_not);
      end
   endtask

   task automatic test_jump();
      logic [31:0] exp_fwd;
      logic [31:0] exp_self;
`ifdef CPU_BRANCH_EN
      exp_fwd  = 32'd44;
      exp_self = 32'd8;
`else
      exp_fwd  = 32'd32;
      exp_self = 32'd12;
`endif
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(NOP_WORD);
      end
      step(32'h0603_0000);
      num_checks++;
      if (bus.PC !== exp_fwd) begin
         num_fails++;
         $display("[TB] FAIL jump_fwd: pc got %h expected %h", bus.PC, exp_fwd);
      end
      do_reset();
      step(NOP_WORD);
      step(NOP_WORD);
      step(32'h06FF_0000);
      num_checks++;
      if (bus.PC !== exp_self) begin
         num_fails++;
         $display("[TB] FAIL jump_self: pc got %h expected %h", bus.PC, exp_self);
      end
   endtask

   task automatic test_undefined();
      logic [7:0] exp_val;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(ins(8'h00, 8'(i), 8'h00, 8'(i * 17 + 1)));
      end
      step(32'hFF12_3456);
      num_checks++;
      if (bus.PC !== 32'd36) begin
         num_fails++;
         $display("[TB] FAIL undef_pc: got %h expected %h", bus.PC, 32'd36);
      end
      for (int i = 0; i < 8; i++) begin
         exp_val = 8'(i * 17 + 1);
         num_checks++;
         if (dut.regs[i] !== exp_val) begin
            num_fails++;
            $display("[TB] FAIL undef_reg%0d: got %h expected %h", i, dut.regs[i], exp_val);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(ins(8'h00, 8'h04, 8'h00, 8'h19));
      step(ins(8'h04, 8'h04, 8'h04, 8'h04));
      num_checks++;
      if (dut.regs[4] !== 8'h32) begin
         num_fails++;
         $display("[TB] FAIL b2b_self_add: r4 got %h expected 32", dut.regs[4]);
      end
      step(ins(8'h04, 8'h05, 8'h04, 8'h04));
      num_checks++;
      if (dut.regs[5] !== 8'h64) begin
         num_fails++;
         $display("[TB] FAIL b2b_raw: r5 got %h expected 64", dut.regs[5]);
      end
      step(ins(8'h05, 8'h05, 8'h05, 8'h04));
      num_checks++;
      if (dut.regs[5] !== 8'h32 || bus.PC !== 32'd16) begin
         num_fails++;
         $display("[TB] FAIL b2b_self_sub: r5 %h pc %h expected r5 32 pc 10", dut.regs[5], bus.PC);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      bus.INSTRUCTION = NOP_WORD;
      #2;
      test_reset();
      test_alu();
      test_sub_wrap();
      test_beq();
      test_jump();
      test_undefined();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
